stage_mem: RTL and testbench
============================

Name: stage_mem

Overview:
- Memory-access stage of the RVX pipeline. It sits between the EX stage and the write-back stage.
- It performs loads and stores over a req/ack data bus and stalls upstream while a bus access is outstanding.
- It aligns and extends load data.
- It registers the MEM/WD pipeline values (wdOp, pcPlus, exResult, memResult, imm) that feed write-back.

Parameters:
- BUS_W, 32 (from RVX_Info.v): datapath width. Byte-lane logic is defined for 32 only.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- validIn  in  1  EX presents an instruction this cycle.
- wdOpIn  in  8  write-back op: [7:3] rd, [2:1] data select, [0] write enable.
- memOpIn  in  5  [0] mem enable, [1] write (1=store), [3:2] size (00 byte, 01 half, 10 word, 11 treated as word), [4] unsigned load.
- exResultIn  in  BUS_W  ALU result; this is the address for memory ops.
- storeDataIn  in  BUS_W  rs2 value for stores.
- pcPlusIn  in  BUS_W  PC+4.
- immIn  in  BUS_W  immediate.
- stallOut  out  1  upstream must hold its outputs.
- busReq  out  1  bus request.
- busWe  out  1  bus write.
- busAddr  out  BUS_W  word-aligned address ({addr[31:2],2'b00}).
- busWData  out  BUS_W  store data, replicated across lanes.
- busBe  out  4  byte enables.
- busAck  in  1  bus completion, single-cycle pulse.
- busRData  in  BUS_W  read data, valid when busAck=1.
- wdOpOut  out  8  registered wdOp to WD.
- pcPlusOut  out  BUS_W  registered.
- exResultOut  out  BUS_W  registered.
- memResultOut  out  BUS_W  registered aligned/extended load data.
- immOut  out  BUS_W  registered.
- misalignOut  out  1  registered one-cycle pulse flagging a misaligned access.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - All registered outputs, busReq, busWe, busAddr, busWData and busBe are driven to 0.
  - stallOut is 0.
  - Reset during WAIT abandons the access: busReq drops immediately and no result is produced.
- State machine has two states, IDLE and WAIT. stallOut = (state==WAIT).
- IDLE, validIn=0: at the next edge wdOpOut becomes 0 (bubble) and misalignOut becomes 0.
- IDLE, validIn=1, memOpIn[0]=0 (non-memory op): at the next edge all inputs are copied to the outputs and memResultOut becomes 0. Latency is 1 cycle.
- IDLE, validIn=1, memOpIn[0]=1, misaligned:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - No bus access is made.
  - At the next edge the outputs are copied with wdOpOut[0] forced to 0 and misalignOut=1 for one cycle.
- IDLE, validIn=1, memOpIn[0]=1, aligned:
  - At edge E0 the op, address, size, unsigned flag and all pass-through fields are captured.
  - busReq/busWe/busAddr/busWData/busBe are registered.
  - state goes to WAIT and wdOpOut becomes 0 (bubble).
  - Upstream advances at E0 (stallOut=0 during the IDLE cycle).
- WAIT:
  - busReq=1; busWe, busAddr, busWData and busBe are held stable.
  - stallOut=1 for every WAIT cycle, including the ack cycle.
  - Inputs are not sampled.
- WAIT with busAck=1: at that edge busReq drops to 0, state goes to IDLE, and the captured fields go to the outputs.
  - Loads: memResultOut = extracted/extended busRData.
  - Stores: memResultOut = 0.
  - Minimum memory-op occupancy is E0 plus 1 WAIT cycle.
- busAck while in IDLE is ignored.
- Byte enables by size and address:
  - byte: busBe = 1<<addr[1:0].
  - half: busBe = 4'b0011<<addr[1:0].
  - word: busBe = 4'b1111.
- Store data replication:
  - byte: busWData = {4{sd[7:0]}}.
  - half: busWData = {2{sd[15:0]}}.
  - word: busWData = sd.
- Load extraction: select the lane busRData[8*addr[1:0] +: 8] (byte) or [16*addr[1] +: 16] (half). Sign-extend unless memOp[4]=1, in which case zero-extend.
- Back-to-back memory ops: the second op is held by upstream during WAIT and is sampled in the IDLE cycle that follows the ack edge.

Decomposition:
- RVX_Info.v gains the following defines:
  - MEMOP field positions: MEMOP_EN=0, MEMOP_WE=1, MEMOP_SZ=3:2, MEMOP_UNS=4.
  - Size codes: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - State encodings: MS_IDLE=1'b0, MS_WAIT=1'b1.
- One combinational sub-module, mem_lane_unit, contains:
  - store replication and busBe generation;
  - the misalignment check;
  - load lane extract and extend.
- stage_mem contains the FSM and the pipeline registers.

Test Plan:
- ALU op: validIn=1, memOp=0, wdOp=8'h0B, exResult=32'h1234 -> next cycle wdOpOut=8'h0B, exResultOut=32'h1234, busReq never asserted, stallOut=0.
- Signed byte load: addr=32'h103, ack after 2 WAIT cycles with busRData=32'h80_00_00_00 -> busAddr=32'h100, busBe=4'b1111 (load uses all lanes), stallOut=1 for 2 cycles, then memResultOut=32'hFFFFFF80. Repeat with memOp[4]=1 -> 32'h00000080.
- Half store: addr=32'h202, sd=32'hAABBCCDD -> busWe=1, busBe=4'b1100, busWData=32'hCCDDCCDD, held stable until ack; after ack state is IDLE.
- Misaligned word load: addr=32'h301 -> no busReq, misalignOut=1 for exactly one cycle, wdOpOut[0]=0.
- Reset mid-access: rst=0 during WAIT -> busReq=0 and stallOut=0 immediately (asynchronous); a later busAck pulse after release produces no output change.
- Back-to-back: a word load followed by a word store, each acked in its first WAIT cycle -> two bus transactions in order, store captured in the IDLE cycle after the load's ack, no lost or duplicated wdOp.

Source files
------------

// File: rtl/stage_mem_pkg.sv
// Shared field positions, size codes, state encoding and the alignment rule
// used by the RVX memory-access stage.
package stage_mem_pkg;

  localparam int MEMOP_EN     = 0;
  localparam int MEMOP_WE     = 1;
  localparam int MEMOP_SZ_LO  = 2;
  localparam int MEMOP_SZ_HI  = 3;
  localparam int MEMOP_UNS    = 4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mstate_e;

  // Size code 2'b11 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    logic r;
    case (sz)
      SZ_B:    r = 1'b0;
      SZ_H:    r = addr_lo[0];
      default: r = (addr_lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stage_mem_lane.sv
// Combinational byte-lane logic: store replication, byte enables,
// misalignment detection and load lane extraction with sign/zero extension.
module mem_lane_unit
  import stage_mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_we,
  input  logic        i_uns,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_load
);

  logic [3:0]  w_be_sz;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store-side lane replication and enables; loads always fetch the whole word.
  always_comb begin
    w_be_sz = 4'b1111;
    o_wdata = i_sdata;
    case (i_size)
      SZ_B: begin
        w_be_sz = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_sdata[7:0]}};
      end
      SZ_H: begin
        w_be_sz = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_sdata[15:0]}};
      end
      default: begin
        w_be_sz = 4'b1111;
        o_wdata = i_sdata;
      end
    endcase
    if (i_we) begin
      o_be = w_be_sz;
    end else begin
      o_be = 4'b1111;
    end
  end

  assign o_misalign = is_misaligned(i_size, i_addr_lo);

  // Load lane select followed by extension to the full word.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
    o_load = i_rdata;
    case (i_size)
      SZ_B: begin
        if (i_uns) begin
          o_load = {24'h000000, w_byte};
        end else begin
          o_load = {{24{w_byte[7]}}, w_byte};
        end
      end
      SZ_H: begin
        if (i_uns) begin
          o_load = {16'h0000, w_half};
        end else begin
          o_load = {{16{w_half[15]}}, w_half};
        end
      end
      default: o_load = i_rdata;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// RVX memory-access stage: req/ack bus FSM, upstream stall and the
// registered MEM/WD pipeline values feeding write-back.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validIn,
  input  logic [7:0]       wdOpIn,
  input  logic [4:0]       memOpIn,
  input  logic [BUS_W-1:0] exResultIn,
  input  logic [BUS_W-1:0] storeDataIn,
  input  logic [BUS_W-1:0] pcPlusIn,
  input  logic [BUS_W-1:0] immIn,
  output logic             stallOut,
  output logic             busReq,
  output logic             busWe,
  output logic [BUS_W-1:0] busAddr,
  output logic [BUS_W-1:0] busWData,
  output logic [3:0]       busBe,
  input  logic             busAck,
  input  logic [BUS_W-1:0] busRData,
  output logic [7:0]       wdOpOut,
  output logic [BUS_W-1:0] pcPlusOut,
  output logic [BUS_W-1:0] exResultOut,
  output logic [BUS_W-1:0] memResultOut,
  output logic [BUS_W-1:0] immOut,
  output logic             misalignOut
);

  mstate_e          r_state;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [BUS_W-1:0] r_bus_addr;
  logic [BUS_W-1:0] r_bus_wdata;
  logic [3:0]       r_bus_be;
  logic [7:0]       r_wdop;
  logic [BUS_W-1:0] r_pc;
  logic [BUS_W-1:0] r_ex;
  logic [BUS_W-1:0] r_mem;
  logic [BUS_W-1:0] r_imm;
  logic             r_misalign;

  // Fields captured at E0 and released to write-back on the ack edge.
  logic [7:0]       r_cap_wdop;
  logic [BUS_W-1:0] r_cap_pc;
  logic [BUS_W-1:0] r_cap_ex;
  logic [BUS_W-1:0] r_cap_imm;
  logic [1:0]       r_cap_sz;
  logic             r_cap_uns;
  logic             r_cap_we;

  logic             w_waiting;
  logic [1:0]       w_lane_addr;
  logic [1:0]       w_lane_sz;
  logic             w_lane_uns;
  logic [3:0]       w_be;
  logic [BUS_W-1:0] w_wdata;
  logic             w_misalign;
  logic [BUS_W-1:0] w_load;

  // In WAIT the lane unit extracts from the captured op; in IDLE it checks the incoming one.
  assign w_waiting   = (r_state == MS_WAIT);
  assign w_lane_addr = w_waiting ? r_cap_ex[1:0] : exResultIn[1:0];
  assign w_lane_sz   = w_waiting ? r_cap_sz : memOpIn[MEMOP_SZ_HI:MEMOP_SZ_LO];
  assign w_lane_uns  = w_waiting ? r_cap_uns : memOpIn[MEMOP_UNS];

  mem_lane_unit u_lane (
    .i_addr_lo  (w_lane_addr),
    .i_size     (w_lane_sz),
    .i_we       (memOpIn[MEMOP_WE]),
    .i_uns      (w_lane_uns),
    .i_sdata    (storeDataIn),
    .i_rdata    (busRData),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign),
    .o_load     (w_load)
  );

  // Bus FSM together with the pipeline and capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= MS_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= {BUS_W{1'b0}};
      r_bus_wdata <= {BUS_W{1'b0}};
      r_bus_be    <= 4'b0000;
      r_wdop      <= 8'h00;
      r_pc        <= {BUS_W{1'b0}};
      r_ex        <= {BUS_W{1'b0}};
      r_mem       <= {BUS_W{1'b0}};
      r_imm       <= {BUS_W{1'b0}};
      r_misalign  <= 1'b0;
      r_cap_wdop  <= 8'h00;
      r_cap_pc    <= {BUS_W{1'b0}};
      r_cap_ex    <= {BUS_W{1'b0}};
      r_cap_imm   <= {BUS_W{1'b0}};
      r_cap_sz    <= 2'b00;
      r_cap_uns   <= 1'b0;
      r_cap_we    <= 1'b0;
    end else begin
      case (r_state)
        MS_IDLE: begin
          r_misalign <= 1'b0;
          if (!validIn) begin
            r_wdop <= 8'h00;
          end else if (!memOpIn[MEMOP_EN]) begin
            r_wdop <= wdOpIn;
            r_pc   <= pcPlusIn;
            r_ex   <= exResultIn;
            r_imm  <= immIn;
            r_mem  <= {BUS_W{1'b0}};
          end else if (w_misalign) begin
            // Faulting access: pass through with the register write suppressed.
            r_wdop     <= {wdOpIn[7:1], 1'b0};
            r_pc       <= pcPlusIn;
            r_ex       <= exResultIn;
            r_imm      <= immIn;
            r_mem      <= {BUS_W{1'b0}};
            r_misalign <= 1'b1;
          end else begin
            r_cap_wdop  <= wdOpIn;
            r_cap_pc    <= pcPlusIn;
            r_cap_ex    <= exResultIn;
            r_cap_imm   <= immIn;
            r_cap_sz    <= memOpIn[MEMOP_SZ_HI:MEMOP_SZ_LO];
            r_cap_uns   <= memOpIn[MEMOP_UNS];
            r_cap_we    <= memOpIn[MEMOP_WE];
            r_bus_req   <= 1'b1;
            r_bus_we    <= memOpIn[MEMOP_WE];
            r_bus_addr  <= {exResultIn[BUS_W-1:2], 2'b00};
            r_bus_wdata <= w_wdata;
            r_bus_be    <= w_be;
            r_wdop      <= 8'h00;
            r_state     <= MS_WAIT;
          end
        end
        MS_WAIT: begin
          r_misalign <= 1'b0;
          if (busAck) begin
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_bus_be  <= 4'b0000;
            r_wdop    <= r_cap_wdop;
            r_pc      <= r_cap_pc;
            r_ex      <= r_cap_ex;
            r_imm     <= r_cap_imm;
            r_mem     <= r_cap_we ? {BUS_W{1'b0}} : w_load;
            r_state   <= MS_IDLE;
          end else begin
            r_state <= MS_WAIT;
          end
        end
        default: begin
          r_state   <= MS_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign stallOut     = w_waiting;
  assign busReq       = r_bus_req;
  assign busWe        = r_bus_we;
  assign busAddr      = r_bus_addr;
  assign busWData     = r_bus_wdata;
  assign busBe        = r_bus_be;
  assign wdOpOut      = r_wdop;
  assign pcPlusOut    = r_pc;
  assign exResultOut  = r_ex;
  assign memResultOut = r_mem;
  assign immOut       = r_imm;
  assign misalignOut  = r_misalign;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: vector table for single-cycle ops, directed bus
// sequences, and a write-back scoreboard fed at issue and drained by a monitor.
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        validIn;
  logic [7:0]  wdOpIn;
  logic [4:0]  memOpIn;
  logic [31:0] exResultIn, storeDataIn, pcPlusIn, immIn;
  logic        stallOut, busReq, busWe, busAck;
  logic [31:0] busAddr, busWData, busRData;
  logic [3:0]  busBe;
  logic [7:0]  wdOpOut;
  logic [31:0] pcPlusOut, exResultOut, memResultOut, immOut;
  logic        misalignOut;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid;
    logic [7:0]  wdop;
    logic [4:0]  memop;
    logic [31:0] ex;
    logic [7:0]  exp_wdop;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [7:0]  wdop;
    logic [31:0] pc;
    logic [31:0] ex;
    logic [31:0] mem;
    logic [31:0] imm;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[9];

  stage_mem #(.BUS_W(32)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .wdOpIn(wdOpIn), .memOpIn(memOpIn),
    .exResultIn(exResultIn), .storeDataIn(storeDataIn), .pcPlusIn(pcPlusIn), .immIn(immIn),
    .stallOut(stallOut), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busWData(busWData), .busBe(busBe), .busAck(busAck), .busRData(busRData),
    .wdOpOut(wdOpOut), .pcPlusOut(pcPlusOut), .exResultOut(exResultOut),
    .memResultOut(memResultOut), .immOut(immOut), .misalignOut(misalignOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Write-back monitor: every non-bubble output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (wdOpOut !== 8'h00) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", {24'h0, wdOpOut}, 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("wb_wdop", {24'h0, wdOpOut}, {24'h0, mon_e.wdop});
          chk("wb_pc",   pcPlusOut,    mon_e.pc);
          chk("wb_ex",   exResultOut,  mon_e.ex);
          chk("wb_mem",  memResultOut, mon_e.mem);
          chk("wb_imm",  immOut,       mon_e.imm);
          chk("wb_mis",  {31'h0, misalignOut}, {31'h0, mon_e.mis});
        end
      end else begin
        chk("bubble_mis", {31'h0, misalignOut}, 32'h0);
      end
    end
  end

  task automatic mem_op(input logic [31:0] addr, input logic [4:0] memop, input logic [31:0] sd,
                        input logic [7:0] wdop, input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_mem, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    exp_t e;
    e.wdop = wdop; e.pc = addr ^ 32'h0001_0000; e.ex = addr;
    e.mem = exp_mem; e.imm = ~addr; e.mis = 1'b0;
    validIn = 1'b1; wdOpIn = wdop; memOpIn = memop; exResultIn = addr;
    storeDataIn = sd; pcPlusIn = e.pc; immIn = e.imm;
    chk("e0_stall", {31'h0, stallOut}, 32'h0);
    sb_q.push_back(e);
    @(negedge clk);
    validIn = 1'b0; wdOpIn = 8'($urandom); exResultIn = $urandom; storeDataIn = $urandom;
    for (int k = 1; k <= waits; k++) begin
      chk("wait_stall", {31'h0, stallOut}, 32'h1);
      chk("wait_req",   {31'h0, busReq},   32'h1);
      chk("wait_we",    {31'h0, busWe},    {31'h0, memop[1]});
      chk("wait_addr",  busAddr, {addr[31:2], 2'b00});
      chk("wait_be",    {28'h0, busBe}, {28'h0, exp_be});
      if (memop[1]) chk("wait_wdata", busWData, exp_wdata);
      if (k == waits) begin
        busAck = 1'b1; busRData = rdata;
      end else begin
        busAck = 1'b0; busRData = $urandom;
      end
      @(negedge clk);
    end
    busAck = 1'b0; busRData = $urandom;
    chk("ack_stall", {31'h0, stallOut}, 32'h0);
    chk("ack_req",   {31'h0, busReq},   32'h0);
  endtask

  initial begin
    rst = 1'b0; validIn = 1'b0; wdOpIn = 8'h00; memOpIn = 5'b00000;
    exResultIn = 32'h0; storeDataIn = 32'h0; pcPlusIn = 32'h0; immIn = 32'h0;
    busAck = 1'b0; busRData = 32'h0;

    vecs[0] = '{1'b1, 8'h0B, 5'b00000, 32'h0000_1234, 8'h0B, 1'b0};
    vecs[1] = '{1'b0, 8'h77, 5'b00000, 32'h0000_0000, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 8'h15, 5'b00010, 32'h0000_0301, 8'h15, 1'b0};
    vecs[3] = '{1'b1, 8'h0D, 5'b01001, 32'h0000_0301, 8'h0C, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 5'b00000, 32'h0000_0000, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 8'h21, 5'b00111, 32'h0000_0105, 8'h20, 1'b1};
    vecs[6] = '{1'b1, 8'h33, 5'b01101, 32'h0000_0302, 8'h32, 1'b1};
    vecs[7] = '{1'b1, 8'h41, 5'b00000, 32'hCAFE_F00D, 8'h41, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 5'b00000, 32'h0000_0000, 8'h00, 1'b0};

    #12;
    chk("rst_stall", {31'h0, stallOut}, 32'h0);
    chk("rst_req",   {31'h0, busReq},   32'h0);
    chk("rst_be",    {28'h0, busBe},    32'h0);
    chk("rst_addr",  busAddr,  32'h0);
    chk("rst_wdop",  {24'h0, wdOpOut},  32'h0);
    chk("rst_mem",   memResultOut, 32'h0);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);

    // Single-cycle table; entry 1 also pulses busAck while idle.
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      validIn = vecs[i].valid; wdOpIn = vecs[i].wdop; memOpIn = vecs[i].memop;
      exResultIn = vecs[i].ex; storeDataIn = 32'h5555_AAAA;
      pcPlusIn = 32'h1000 + 32'(i) * 32'd4; immIn = 32'(i) * 32'd16 + 32'd7;
      busAck = (i == 1); busRData = 32'hFFFF_FFFF;
      if (vecs[i].valid) begin
        e.wdop = vecs[i].exp_wdop; e.pc = pcPlusIn; e.ex = vecs[i].ex;
        e.mem = 32'h0; e.imm = immIn; e.mis = vecs[i].exp_mis;
        sb_q.push_back(e);
      end
      @(negedge clk);
      chk("tbl_req",   {31'h0, busReq},   32'h0);
      chk("tbl_stall", {31'h0, stallOut}, 32'h0);
    end
    validIn = 1'b0; busAck = 1'b0;
    @(negedge clk);

    mem_op(32'h103, 5'b00001, 32'h11, 8'h29, 2, 32'h8000_0000, 32'hFFFF_FF80, 4'b1111, 32'h0);
    mem_op(32'h103, 5'b10001, 32'h11, 8'h2B, 2, 32'h8000_0000, 32'h0000_0080, 4'b1111, 32'h0);
    mem_op(32'h202, 5'b00111, 32'hAABB_CCDD, 8'h2D, 3, 32'h0, 32'h0, 4'b1100, 32'hCCDD_CCDD);
    @(negedge clk);
    mem_op(32'h502, 5'b00101, 32'h0, 8'h31, 1, 32'h8001_7FFF, 32'hFFFF_8001, 4'b1111, 32'h0);
    mem_op(32'h601, 5'b00011, 32'h1234_565A, 8'h37, 1, 32'h0, 32'h0, 4'b0010, 32'h5A5A_5A5A);
    @(negedge clk);

    // Back-to-back: store issued in the idle cycle right after the load's ack.
    mem_op(32'h400, 5'b01001, 32'h0, 8'h45, 1, 32'h1234_5678, 32'h1234_5678, 4'b1111, 32'h0);
    mem_op(32'h404, 5'b01011, 32'hDEAD_BEEF, 8'h47, 1, 32'h0, 32'h0, 4'b1111, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    chk("b2b_drained", sb_q.size(), 32'h0);

    // Reset in WAIT abandons the access; a late ack must produce nothing.
    validIn = 1'b1; wdOpIn = 8'h51; memOpIn = 5'b01001; exResultIn = 32'h700;
    pcPlusIn = 32'h704; immIn = 32'h9;
    @(negedge clk);
    validIn = 1'b0;
    chk("rw_req_before", {31'h0, busReq}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rw_req_async",   {31'h0, busReq},   32'h0);
    chk("rw_stall_async", {31'h0, stallOut}, 32'h0);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    busAck = 1'b1; busRData = 32'h1357_9BDF;
    @(negedge clk);
    busAck = 1'b0;
    repeat (3) @(negedge clk);
    chk("rw_req_after",   {31'h0, busReq},   32'h0);
    chk("rw_wdop_after",  {24'h0, wdOpOut},  32'h0);
    chk("final_drained",  sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
